// File: rtl/atm_session_if.sv
// Request/response handshake bundle between the ATM front end and atm_session_ctrl.
// The front end is the master; the session controller is the slave.
interface atm_session_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [9:0]  req_card;
    logic [10:0] req_pin;
    logic [10:0] req_amount;
    logic        resp_valid;
    logic        resp_ready;
    logic [2:0]  resp_status;
    logic [10:0] resp_bal;

    modport master (
        output req_valid, req_op, req_card, req_pin, req_amount, resp_ready,
        input  req_ready, resp_valid, resp_status, resp_bal
    );

    modport slave (
        input  req_valid, req_op, req_card, req_pin, req_amount, resp_ready,
        output req_ready, resp_valid, resp_status, resp_bal
    );
endinterface

// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: accept, linear account scan, auth, single balance write-back.
// Define PIN_LOCKOUT_EN to add a saturating per-account PIN failure lockout.
module atm_session_ctrl #(
    parameter  int N  = 4,
    localparam int AW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    atm_session_if.slave  bus,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [9:0]    mem_card,
    input  logic [10:0]   mem_pin,
    input  logic [10:0]   mem_bal,
    output logic          bal_wr_en,
    output logic [10:0]   bal_wr_data,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN_RD,
        SCAN_CMP,
        EXEC,
        RESP
    } state_t;

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_BAD_AUTH = 3'd1;
    localparam logic [2:0] ST_NO_FUNDS = 3'd2;
    localparam logic [2:0] ST_OVERFLOW = 3'd3;
    localparam logic [2:0] ST_BAD_OP   = 3'd4;
    localparam logic [2:0] ST_LOCKED   = 3'd5;

    localparam logic [1:0] OP_WD  = 2'b01;
    localparam logic [1:0] OP_DEP = 2'b10;
    localparam logic [1:0] OP_BAD = 2'b11;

    state_t      state;
    logic [1:0]  op_q;
    logic [9:0]  card_q;
    logic [10:0] pin_q;
    logic [10:0] amt_q;

    logic [11:0] sum;
    logic        x_wr;
    logic [10:0] x_data;
    logic [2:0]  x_status;
    logic [10:0] x_bal;
    logic        locked;

`ifdef PIN_LOCKOUT_EN
    logic [1:0] fail_cnt [0:N];
    assign locked = (fail_cnt[mem_addr] == 2'd3);
`else
    assign locked = 1'b0;
`endif

    // Operation result is resolved from the live read data so EXEC only has to strobe it out.
    always_comb begin
        sum      = {1'b0, mem_bal} + {1'b0, amt_q};
        x_wr     = 1'b0;
        x_data   = mem_bal;
        x_status = ST_OK;
        x_bal    = mem_bal;
        unique case (1'b1)
            op_q == OP_WD: begin
                if (mem_bal >= amt_q) begin
                    x_wr   = 1'b1;
                    x_data = mem_bal - amt_q;
                    x_bal  = mem_bal - amt_q;
                end else begin
                    x_status = ST_NO_FUNDS;
                end
            end
            op_q == OP_DEP: begin
                if (sum[11]) begin
                    x_status = ST_OVERFLOW;
                end else begin
                    x_wr   = 1'b1;
                    x_data = sum[10:0];
                    x_bal  = sum[10:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.req_ready   <= 1'b1;
            busy            <= 1'b0;
            mem_rd_en       <= 1'b0;
            mem_addr        <= '0;
            bal_wr_en       <= 1'b0;
            bal_wr_data     <= '0;
            bus.resp_valid  <= 1'b0;
            bus.resp_status <= ST_OK;
            bus.resp_bal    <= '0;
            op_q            <= '0;
            card_q          <= '0;
            pin_q           <= '0;
            amt_q           <= '0;
`ifdef PIN_LOCKOUT_EN
            for (int i = 0; i <= N; i++) fail_cnt[i] <= 2'd0;
`endif
        end else begin
            mem_rd_en <= 1'b0;
            bal_wr_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q          <= bus.req_op;
                        card_q        <= bus.req_card;
                        pin_q         <= bus.req_pin;
                        amt_q         <= bus.req_amount;
                        bus.req_ready <= 1'b0;
                        busy          <= 1'b1;
                        if (bus.req_op == OP_BAD) begin
                            bus.resp_status <= ST_BAD_OP;
                            bus.resp_bal    <= '0;
                            bus.resp_valid  <= 1'b1;
                            state           <= RESP;
                        end else begin
                            mem_addr  <= '0;
                            mem_rd_en <= 1'b1;
                            state     <= SCAN_RD;
                        end
                    end
                end
                SCAN_RD: state <= SCAN_CMP;
                SCAN_CMP: begin
                    if (mem_card != card_q) begin
                        if (mem_addr == AW'(N)) begin
                            bus.resp_status <= ST_BAD_AUTH;
                            bus.resp_bal    <= '0;
                            bus.resp_valid  <= 1'b1;
                            state           <= RESP;
                        end else begin
                            mem_addr  <= mem_addr + AW'(1);
                            mem_rd_en <= 1'b1;
                            state     <= SCAN_RD;
                        end
                    end else if (locked) begin
                        bus.resp_status <= ST_LOCKED;
                        bus.resp_bal    <= mem_bal;
                        bus.resp_valid  <= 1'b1;
                        state           <= RESP;
                    end else if (mem_pin != pin_q) begin
`ifdef PIN_LOCKOUT_EN
                        fail_cnt[mem_addr] <= fail_cnt[mem_addr] + 2'd1;
`endif
                        bus.resp_status <= ST_BAD_AUTH;
                        bus.resp_bal    <= mem_bal;
                        bus.resp_valid  <= 1'b1;
                        state           <= RESP;
                    end else begin
`ifdef PIN_LOCKOUT_EN
                        fail_cnt[mem_addr] <= 2'd0;
`endif
                        bal_wr_en       <= x_wr;
                        bal_wr_data     <= x_wr ? x_data : bal_wr_data;
                        bus.resp_status <= x_status;
                        bus.resp_bal    <= x_bal;
                        state           <= EXEC;
                    end
                end
                EXEC: begin
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
